// File: rtl/lc3b_mem_seq_pkg.sv
// Shared types for the LC-3b data-side memory sequencer: FSM state encoding,
// byte-lane write masks and a helper that picks the next access state.
package lc3b_mem_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IND_RD  = 3'd1,
        ST_ACC_RD  = 3'd2,
        ST_ACC_WR  = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_DONE    = 3'd5
    } lc3b_memseq_state;

    localparam logic [1:0] WMASK_WORD = 2'b11;
    localparam logic [1:0] WMASK_LO   = 2'b01;
    localparam logic [1:0] WMASK_HI   = 2'b10;

    function automatic logic is_access(input lc3b_memseq_state s);
        return (s == ST_IND_RD) || (s == ST_ACC_RD) || (s == ST_ACC_WR);
    endfunction

    function automatic lc3b_memseq_state access_state(input logic more_ind, input logic write);
        if (more_ind)
            return ST_IND_RD;
        return write ? ST_ACC_WR : ST_ACC_RD;
    endfunction

endpackage

// File: rtl/lc3b_mem_seq_timeout_ctr.sv
// Per-access timeout and retry bookkeeping for lc3b_mem_seq.
// tcnt restarts whenever the sequencer is not strobing; rcnt restarts per access.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int RETRIES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    input  logic mem_resp,
    output logic expire,
    output logic exhausted
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;

    assign expire    = busy && !mem_resp && (tcnt == TW'(TIMEOUT - 1));
    assign exhausted = (rcnt >= RW'(RETRIES));

    always_ff @(posedge clk) begin
        if (rst || clear || !busy || expire)
            tcnt <= '0;
        else if (!mem_resp)
            tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || clear)
            rcnt <= '0;
        else if (expire && !exhausted)
            rcnt <= rcnt + RW'(1);
    end

endmodule

// File: rtl/lc3b_mem_seq.sv
// LC-3b data-side memory sequencer. States: IDLE accept | IND_RD pointer read |
// ACC_RD/ACC_WR data access | BACKOFF one idle cycle before retry | DONE response pulse.
module lc3b_mem_seq
    import lc3b_mem_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_IND = 2,
    parameter int TIMEOUT = 255,
    parameter int RETRIES = 1,
    localparam int IW     = (MAX_IND > 0) ? $clog2(MAX_IND + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic [IW-1:0]    req_ind,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [WIDTH-1:0] mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [1:0]       mem_byte_enable,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_resp
);

    typedef struct packed {
        logic             write;
        logic             byte_acc;
        logic [IW-1:0]    ind;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] wdata;
    } lc3b_memseq_req;

    lc3b_memseq_state state, state_nx;
    lc3b_memseq_req   req_q, req_nx;
    logic [WIDTH-1:0] rdata_q, rdata_nx;
    logic             err_q, err_nx;

    logic             ctr_clear;
    logic             ctr_busy;
    logic             expire;
    logic             exhausted;

    logic [WIDTH-1:0] word_addr;
    logic [WIDTH-1:0] acc_addr;
    logic [WIDTH-1:0] lane_rdata;
    logic [WIDTH-1:0] byte_wdata;

    assign ctr_busy  = is_access(state);
    assign ctr_clear = (state == ST_IDLE) || (ctr_busy && mem_resp);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .RETRIES (RETRIES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear     (ctr_clear),
        .busy      (ctr_busy),
        .mem_resp  (mem_resp),
        .expire    (expire),
        .exhausted (exhausted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            req_q   <= req_nx;
            rdata_q <= rdata_nx;
            err_q   <= err_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        req_nx          = req_q;
        rdata_nx        = rdata_q;
        err_nx          = err_q;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_rdata       = '0;
        rsp_err         = 1'b0;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_wdata       = '0;
        mem_byte_enable = WMASK_WORD;

        word_addr       = req_q.addr;
        word_addr[0]    = 1'b0;
        acc_addr        = req_q.byte_acc ? req_q.addr : word_addr;
        lane_rdata      = '0;
        lane_rdata[7:0] = req_q.addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        byte_wdata       = '0;
        byte_wdata[15:0] = {req_q.wdata[7:0], req_q.wdata[7:0]};

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_nx.write    = req_write;
                    req_nx.byte_acc = req_byte;
                    req_nx.ind      = req_ind;
                    req_nx.addr     = req_addr;
                    req_nx.wdata    = req_wdata;
                    rdata_nx        = '0;
                    err_nx          = 1'b0;
                    if (req_ind > IW'(MAX_IND)) begin
                        err_nx   = 1'b1;
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = access_state(req_ind != '0, req_write);
                    end
                end
            end

            ST_IND_RD: begin
                mem_read    = 1'b1;
                mem_address = word_addr;
                if (mem_resp) begin
                    req_nx.addr = mem_rdata;
                    req_nx.ind  = req_q.ind - IW'(1);
                    state_nx    = access_state(req_q.ind > IW'(1), req_q.write);
                end
            end

            ST_ACC_RD: begin
                mem_read    = 1'b1;
                mem_address = acc_addr;
                if (mem_resp) begin
                    rdata_nx = req_q.byte_acc ? lane_rdata : mem_rdata;
                    state_nx = ST_DONE;
                end
            end

            ST_ACC_WR: begin
                mem_write   = 1'b1;
                mem_address = acc_addr;
                if (req_q.byte_acc) begin
                    mem_wdata       = byte_wdata;
                    mem_byte_enable = req_q.addr[0] ? WMASK_HI : WMASK_LO;
                end else begin
                    mem_wdata       = req_q.wdata;
                end
                if (mem_resp)
                    state_nx = ST_DONE;
            end

            ST_BACKOFF: begin
                // Remaining indirection count tells us which access to resume.
                state_nx = access_state(req_q.ind != '0, req_q.write);
            end

            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                state_nx  = ST_IDLE;
            end

            default: state_nx = ST_IDLE;
        endcase

        // expire is already qualified by !mem_resp, so a coincident response wins.
        if (expire) begin
            if (exhausted) begin
                err_nx   = 1'b1;
                state_nx = ST_DONE;
            end else begin
                state_nx = ST_BACKOFF;
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_seq.sv
// Directed bench for lc3b_mem_seq (WIDTH=16, MAX_IND=2, TIMEOUT=4, RETRIES=1).
module tb_lc3b_mem_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [1:0]  req_ind = 2'd0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_resp = 1'b0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lc3b_mem_seq #(
        .WIDTH   (16),
        .MAX_IND (2),
        .TIMEOUT (4),
        .RETRIES (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_byte        (req_byte),
        .req_ind         (req_ind),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns just after the accepting edge.
    task automatic issue(input logic w, input logic b, input logic [1:0] ind,
                         input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_ind   = ind;
        req_addr  = a;
        req_wdata = d;
        tick;
        req_valid = 1'b0;
        req_addr  = 16'hFFFF;
        req_wdata = 16'hFFFF;
    endtask

    // Waits for a strobe, holds mem_resp low for 'waits' cycles, then responds.
    task automatic serve(input int waits, input logic [15:0] data,
                         output int dly, output logic [15:0] addr, output logic is_wr,
                         output logic [15:0] wd, output logic [1:0] be, output int held);
        dly = 0;
        while (!(mem_read || mem_write) && dly < 20) begin
            tick;
            dly++;
        end
        addr  = mem_address;
        is_wr = mem_write;
        wd    = mem_wdata;
        be    = mem_byte_enable;
        held  = 0;
        for (int i = 0; i < waits; i++) begin
            if (mem_read || mem_write) held++;
            tick;
        end
        if (mem_read || mem_write) held++;
        mem_resp  = 1'b1;
        mem_rdata = data;
        tick;
        mem_resp  = 1'b0;
        mem_rdata = 16'h0;
    endtask

    // Waits (bounded) for rsp_valid; reports whether it dropped the next cycle.
    task automatic wait_rsp(output int lat, output logic seen, output logic [15:0] rd,
                            output logic er, output logic after);
        lat = 0;
        while (!rsp_valid && lat < 12) begin
            tick;
            lat++;
        end
        seen  = rsp_valid;
        rd    = rsp_rdata;
        er    = rsp_err;
        tick;
        after = rsp_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        total++; if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b10000) $display("FAIL reset_ctl got %b want 10000", {req_ready, rsp_valid, rsp_err, mem_read, mem_write}); else passed++;
        total++; if (mem_byte_enable !== 2'b11) $display("FAIL reset_be got %b want 11", mem_byte_enable); else passed++;
        total++; if (mem_address !== 16'h0 || mem_wdata !== 16'h0) $display("FAIL reset_mem got %h/%h want 0000/0000", mem_address, mem_wdata); else passed++;
        total++; if (rsp_rdata !== 16'h0) $display("FAIL reset_rdata got %h want 0000", rsp_rdata); else passed++;
    endtask

    task automatic test_word_load;
        int dly, held, lat;
        logic [15:0] addr, wd, rd;
        logic [1:0] be;
        logic is_wr, seen, er, after;
        issue(1'b0, 1'b0, 2'd0, 16'h3001, 16'h0);
        total++; if (req_ready !== 1'b0) $display("FAIL wl_busy_ready got %b want 0", req_ready); else passed++;
        serve(2, 16'h1234, dly, addr, is_wr, wd, be, held);
        total++; if (addr !== 16'h3000) $display("FAIL wl_addr got %h want 3000", addr); else passed++;
        total++; if (is_wr !== 1'b0 || held != 3) $display("FAIL wl_strobe got wr=%b held=%0d want wr=0 held=3", is_wr, held); else passed++;
        wait_rsp(lat, seen, rd, er, after);
        total++; if (seen !== 1'b1 || lat != 0) $display("FAIL wl_rsp got seen=%b lat=%0d want 1/0", seen, lat); else passed++;
        total++; if (rd !== 16'h1234 || er !== 1'b0) $display("FAIL wl_data got %h err=%b want 1234 err=0", rd, er); else passed++;
        total++; if (after !== 1'b0) $display("FAIL wl_pulse got %b want 0", after); else passed++;
    endtask

    task automatic test_latency;
        int dly, held, lat;
        logic [15:0] addr, wd, rd;
        logic [1:0] be;
        logic is_wr, seen, er, after;
        issue(1'b0, 1'b0, 2'd0, 16'h2000, 16'h0);
        serve(0, 16'h0F0F, dly, addr, is_wr, wd, be, held);
        total++; if (dly != 0) $display("FAIL lat_strobe got %0d want 0", dly); else passed++;
        wait_rsp(lat, seen, rd, er, after);
        total++; if (lat != 0 || rd !== 16'h0F0F) $display("FAIL lat_rsp got lat=%0d data=%h want 0/0f0f", lat, rd); else passed++;
    endtask

    task automatic test_byte;
        int dly, held, lat;
        logic [15:0] addr, wd, rd;
        logic [1:0] be;
        logic is_wr, seen, er, after;
        issue(1'b0, 1'b1, 2'd0, 16'h3001, 16'h0);
        serve(0, 16'hABCD, dly, addr, is_wr, wd, be, held);
        wait_rsp(lat, seen, rd, er, after);
        total++; if (rd !== 16'h00AB) $display("FAIL lb_hi got %h want 00ab", rd); else passed++;
        issue(1'b0, 1'b1, 2'd0, 16'h3000, 16'h0);
        serve(1, 16'hABCD, dly, addr, is_wr, wd, be, held);
        wait_rsp(lat, seen, rd, er, after);
        total++; if (rd !== 16'h00CD) $display("FAIL lb_lo got %h want 00cd", rd); else passed++;
        issue(1'b1, 1'b1, 2'd0, 16'h3000, 16'h00EE);
        serve(0, 16'h0, dly, addr, is_wr, wd, be, held);
        total++; if (is_wr !== 1'b1 || wd !== 16'hEEEE || be !== 2'b01) $display("FAIL sb_lo got wr=%b wd=%h be=%b want 1/eeee/01", is_wr, wd, be); else passed++;
        wait_rsp(lat, seen, rd, er, after);
        total++; if (seen !== 1'b1 || rd !== 16'h0 || er !== 1'b0) $display("FAIL sb_rsp got %b/%h/%b want 1/0000/0", seen, rd, er); else passed++;
        issue(1'b1, 1'b1, 2'd0, 16'h3001, 16'h1234);
        serve(0, 16'h0, dly, addr, is_wr, wd, be, held);
        total++; if (wd !== 16'h3434 || be !== 2'b10) $display("FAIL sb_hi got wd=%h be=%b want 3434/10", wd, be); else passed++;
        wait_rsp(lat, seen, rd, er, after);
        issue(1'b1, 1'b0, 2'd0, 16'h3002, 16'hBEEF);
        serve(0, 16'h0, dly, addr, is_wr, wd, be, held);
        total++; if (addr !== 16'h3002 || wd !== 16'hBEEF || be !== 2'b11) $display("FAIL sw got %h/%h/%b want 3002/beef/11", addr, wd, be); else passed++;
        wait_rsp(lat, seen, rd, er, after);
    endtask

    task automatic test_indirect;
        int dly, held, lat;
        logic [15:0] addr, wd, rd;
        logic [1:0] be;
        logic is_wr, seen, er, after;
        issue(1'b0, 1'b0, 2'd1, 16'h4000, 16'h0);
        serve(0, 16'h5002, dly, addr, is_wr, wd, be, held);
        total++; if (addr !== 16'h4000 || is_wr !== 1'b0) $display("FAIL ind1_ptr got %h wr=%b want 4000 wr=0", addr, is_wr); else passed++;
        serve(1, 16'h7777, dly, addr, is_wr, wd, be, held);
        total++; if (addr !== 16'h5002 || dly != 0) $display("FAIL ind1_data got %h dly=%0d want 5002/0", addr, dly); else passed++;
        wait_rsp(lat, seen, rd, er, after);
        total++; if (rd !== 16'h7777 || er !== 1'b0 || lat != 0) $display("FAIL ind1_rsp got %h err=%b lat=%0d want 7777/0/0", rd, er, lat); else passed++;
        issue(1'b0, 1'b0, 2'd2, 16'h4000, 16'h0);
        serve(0, 16'h6000, dly, addr, is_wr, wd, be, held);
        total++; if (addr !== 16'h4000) $display("FAIL ind2_a0 got %h want 4000", addr); else passed++;
        serve(2, 16'h6101, dly, addr, is_wr, wd, be, held);
        total++; if (addr !== 16'h6000) $display("FAIL ind2_a1 got %h want 6000", addr); else passed++;
        serve(0, 16'h0042, dly, addr, is_wr, wd, be, held);
        total++; if (addr !== 16'h6100) $display("FAIL ind2_a2 got %h want 6100", addr); else passed++;
        wait_rsp(lat, seen, rd, er, after);
        total++; if (rd !== 16'h0042 || er !== 1'b0) $display("FAIL ind2_rsp got %h err=%b want 0042/0", rd, er); else passed++;
        issue(1'b1, 1'b0, 2'd1, 16'h4000, 16'hCAFE);
        serve(0, 16'h5004, dly, addr, is_wr, wd, be, held);
        serve(0, 16'h0, dly, addr, is_wr, wd, be, held);
        total++; if (addr !== 16'h5004 || is_wr !== 1'b1 || wd !== 16'hCAFE) $display("FAIL sti got %h wr=%b wd=%h want 5004/1/cafe", addr, is_wr, wd); else passed++;
        wait_rsp(lat, seen, rd, er, after);
    endtask

    task automatic test_bad_ind;
        int strobes, lat;
        logic [15:0] rd;
        logic seen, er, after;
        issue(1'b0, 1'b0, 2'd3, 16'h1000, 16'h0);
        strobes = (mem_read || mem_write) ? 1 : 0;
        wait_rsp(lat, seen, rd, er, after);
        total++; if (seen !== 1'b1 || er !== 1'b1 || lat != 0) $display("FAIL bad_ind got seen=%b err=%b lat=%0d want 1/1/0", seen, er, lat); else passed++;
        total++; if (strobes != 0) $display("FAIL bad_ind_strobe got %0d want 0", strobes); else passed++;
    endtask

    task automatic test_timeout;
        int s, g;
        s = 0;
        g = 0;
        issue(1'b0, 1'b0, 2'd0, 16'h3100, 16'h0);
        for (int i = 0; i < 30 && !rsp_valid; i++) begin
            if (mem_read) s++; else g++;
            tick;
        end
        total++; if (s != 8 || g != 1) $display("FAIL to_cycles got strobe=%0d gap=%0d want 8/1", s, g); else passed++;
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0) $display("FAIL to_rsp got %b/%b/%h want 1/1/0000", rsp_valid, rsp_err, rsp_rdata); else passed++;
        tick;
    endtask

    task automatic test_timeout_race;
        int dly, held, lat;
        logic [15:0] addr, wd, rd;
        logic [1:0] be;
        logic is_wr, seen, er, after;
        issue(1'b0, 1'b0, 2'd0, 16'h3200, 16'h0);
        serve(3, 16'h5A5A, dly, addr, is_wr, wd, be, held);
        wait_rsp(lat, seen, rd, er, after);
        total++; if (held != 4 || lat != 0 || rd !== 16'h5A5A || er !== 1'b0) $display("FAIL race got held=%0d lat=%0d %h err=%b want 4/0/5a5a/0", held, lat, rd, er); else passed++;
        issue(1'b0, 1'b0, 2'd0, 16'h3300, 16'h0);
        serve(6, 16'hC0DE, dly, addr, is_wr, wd, be, held);
        wait_rsp(lat, seen, rd, er, after);
        total++; if (held != 6 || rd !== 16'hC0DE || er !== 1'b0) $display("FAIL retry_ok got held=%0d %h err=%b want 6/c0de/0", held, rd, er); else passed++;
    endtask

    task automatic test_reset_mid;
        int rsp_seen;
        issue(1'b0, 1'b0, 2'd1, 16'h4000, 16'h0);
        tick;
        total++; if (mem_read !== 1'b1 || mem_address !== 16'h4000) $display("FAIL rm_ind got %b/%h want 1/4000", mem_read, mem_address); else passed++;
        rst = 1'b1;
        tick;
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) $display("FAIL rm_drop got rd=%b wr=%b rdy=%b want 0/0/1", mem_read, mem_write, req_ready); else passed++;
        rst = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) rsp_seen++;
            tick;
        end
        total++; if (rsp_seen != 0) $display("FAIL rm_norsp got %0d want 0", rsp_seen); else passed++;
    endtask

    task automatic test_back_to_back;
        int dly, held, lat;
        logic [15:0] addr, wd, rd;
        logic [1:0] be;
        logic is_wr, seen, er, after;
        issue(1'b0, 1'b0, 2'd0, 16'h3001, 16'h0);
        serve(0, 16'h1111, dly, addr, is_wr, wd, be, held);
        wait_rsp(lat, seen, rd, er, after);
        total++; if (seen !== 1'b1 || rd !== 16'h1111 || er !== 1'b0) $display("FAIL b2b_0 got %b/%h/%b want 1/1111/0", seen, rd, er); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", req_ready); else passed++;
        issue(1'b0, 1'b0, 2'd0, 16'h3010, 16'h0);
        serve(1, 16'h2222, dly, addr, is_wr, wd, be, held);
        wait_rsp(lat, seen, rd, er, after);
        total++; if (addr !== 16'h3010 || rd !== 16'h2222) $display("FAIL b2b_1 got %h/%h want 3010/2222", addr, rd); else passed++;
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_latency;
        test_byte;
        test_indirect;
        test_bad_ind;
        test_timeout;
        test_timeout_race;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
